// File: rtl/microcode_sequencer_pkg.sv
// Shared types for the SAP CPU control unit: control word layout, sequencer states,
// opcode encodings, ALU operation codes and the per-opcode execute-step count.
package microcode_sequencer_pkg;

  localparam int OPCODE_W = 4;
  localparam int STEP_W   = 2;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_JN  = 4'h9,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    FETCH_ADDR = 3'd0,
    FETCH_INST = 3'd1,
    DECODE     = 3'd2,
    EXEC       = 3'd3,
    HALT       = 3'd4
  } seq_state_t;

  typedef struct packed {
    logic       pc_enable;
    logic       load_pc;
    logic       oe_pc;
    logic       load_mar;
    logic       oe_ram;
    logic       load_ram;
    logic       load_ir;
    logic       oe_ir;
    logic       load_a;
    logic       oe_a;
    logic       load_b;
    logic       alu_oe;
    logic [1:0] alu_op;
    logic       load_flags;
    logic       load_o;
    logic       halt;
  } control_word_t;

  // Zero means the opcode has no EXEC phase (NOP, HLT and undefined encodings).
  function automatic logic [STEP_W:0] exec_steps(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_LDA, OP_STA:                 return 3'd2;
      OP_ADD, OP_SUB:                 return 3'd3;
      OP_LDI, OP_JMP, OP_JC, OP_JZ,
      OP_JN, OP_OUT:                  return 3'd1;
      default:                        return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/microcode_rom.sv
// Combinational opcode table: maps the latched opcode, execute step and flags
// to the EXEC-phase control word, and flags the final step of the instruction.
module microcode_rom
  import microcode_sequencer_pkg::*;
(
  input  opcode_t             op,
  input  logic [STEP_W-1:0]   step,
  input  logic                flag_zero,
  input  logic                flag_carry,
  input  logic                flag_negative,
  output control_word_t       cw,
  output logic                last_step
);

  logic [STEP_W:0] steps;

  assign steps     = exec_steps(op);
  assign last_step = ({1'b0, step} == (steps - 3'd1));

  always_comb begin
    cw = '0;
    case (op)
      OP_LDA, OP_STA: begin
        if (step == 2'd0) begin
          cw.oe_ir    = 1'b1;
          cw.load_mar = 1'b1;
        end else if (op == OP_LDA) begin
          cw.oe_ram = 1'b1;
          cw.load_a = 1'b1;
        end else begin
          cw.oe_a     = 1'b1;
          cw.load_ram = 1'b1;
        end
      end
      OP_ADD, OP_SUB: begin
        if (step == 2'd0) begin
          cw.oe_ir    = 1'b1;
          cw.load_mar = 1'b1;
        end else if (step == 2'd1) begin
          cw.oe_ram = 1'b1;
          cw.load_b = 1'b1;
        end else begin
          cw.alu_oe     = 1'b1;
          cw.alu_op     = (op == OP_ADD) ? ALU_ADD : ALU_SUB;
          cw.load_a     = 1'b1;
          cw.load_flags = 1'b1;
        end
      end
      OP_LDI: begin
        cw.oe_ir  = 1'b1;
        cw.load_a = 1'b1;
      end
      OP_JMP: begin
        cw.oe_ir   = 1'b1;
        cw.load_pc = 1'b1;
      end
      // Conditional jumps look at the flags only in E0; the step guard keeps it that way.
      OP_JC, OP_JZ, OP_JN: begin
        if (step == 2'd0 &&
            ((op == OP_JC && flag_carry) ||
             (op == OP_JZ && flag_zero)  ||
             (op == OP_JN && flag_negative))) begin
          cw.oe_ir   = 1'b1;
          cw.load_pc = 1'b1;
        end
      end
      OP_OUT: begin
        cw.oe_a   = 1'b1;
        cw.load_o = 1'b1;
      end
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/microcode_sequencer.sv
// SAP CPU control unit: fetch/decode/execute FSM that drives one control word per
// cycle, delegating the execute-phase opcode table to microcode_rom.
module microcode_sequencer
  import microcode_sequencer_pkg::*;
#(
  parameter int OPCODE_WIDTH = OPCODE_W,
  parameter int STEP_WIDTH   = STEP_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [OPCODE_WIDTH-1:0] opcode_i,
  input  logic                    flag_zero_i,
  input  logic                    flag_carry_i,
  input  logic                    flag_negative_i,
  output control_word_t           control_word_o,
  output seq_state_t              state_o,
  output logic [STEP_WIDTH-1:0]   step_o,
  output logic                    instr_done_o,
  output logic                    halted_o
);

  seq_state_t              state, state_n;
  logic [STEP_WIDTH-1:0]   step, step_n;
  opcode_t                 op_q;
  control_word_t           cw, rom_cw;
  logic                    rom_last, done;

  microcode_rom u_rom (
    .op            (op_q),
    .step          (step),
    .flag_zero     (flag_zero_i),
    .flag_carry    (flag_carry_i),
    .flag_negative (flag_negative_i),
    .cw            (rom_cw),
    .last_step     (rom_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH_ADDR;
      step  <= '0;
      op_q  <= OP_NOP;
    end else begin
      state <= state_n;
      step  <= step_n;
      if (state == DECODE) op_q <= opcode_t'(opcode_i);
    end
  end

  // DECODE looks at opcode_i directly because op_q only captures it at the end of that cycle.
  always_comb begin
    state_n = state;
    step_n  = step;
    cw      = '0;
    done    = 1'b0;
    case (state)
      FETCH_ADDR: begin
        cw.oe_pc    = 1'b1;
        cw.load_mar = 1'b1;
        state_n     = FETCH_INST;
      end
      FETCH_INST: begin
        cw.oe_ram    = 1'b1;
        cw.load_ir   = 1'b1;
        cw.pc_enable = 1'b1;
        state_n      = DECODE;
      end
      DECODE: begin
        step_n = '0;
        if (opcode_i == OP_HLT) begin
          state_n = HALT;
        end else if (exec_steps(opcode_i) == '0) begin
          state_n = FETCH_ADDR;
          done    = 1'b1;
        end else begin
          state_n = EXEC;
        end
      end
      EXEC: begin
        cw = rom_cw;
        if (rom_last) begin
          done    = 1'b1;
          step_n  = '0;
          state_n = FETCH_ADDR;
        end else begin
          step_n = step + STEP_WIDTH'(1);
        end
      end
      HALT: begin
        cw.halt = 1'b1;
      end
      default: begin
        state_n = FETCH_ADDR;
        step_n  = '0;
      end
    endcase
  end

  assign control_word_o = reset ? '0 : cw;
  assign instr_done_o   = !reset && done;
  assign halted_o       = !reset && (state == HALT);
  assign state_o        = state;
  assign step_o         = step;

endmodule

// File: doc/microcode_sequencer.md
Name: microcode_sequencer

Overview:
- Control unit for the 8-bit SAP CPU.
- Sequences fetch, decode and execute for every instruction and drives one control word into the shared bus, RAM, PC, A/B registers, ALU, flags register and output register.
- Evaluates conditional jumps against the flags register outputs.
- Sits inside the cpu; the instruction register is its opcode source.

Parameters:
- OPCODE_WIDTH, 4, width of the opcode field taken from the IR upper nibble.
- STEP_WIDTH, 2, width of the execute-step counter (max 4 execute steps).

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clk.
- opcode_i  in  OPCODE_WIDTH  IR opcode field; valid in DECODE.
- flag_zero_i  in  1  flags register Z.
- flag_carry_i  in  1  flags register C.
- flag_negative_i  in  1  flags register N.
- control_word_o  out  control_word_t  control signals to the datapath.
- state_o  out  seq_state_t  current state, for debug and bench.
- step_o  out  STEP_WIDTH  current execute step.
- instr_done_o  out  1  high on the final cycle of each instruction.
- halted_o  out  1  high while in HALT.

Behaviour:
- **State machine:** FETCH_ADDR -> FETCH_INST -> DECODE -> EXEC (steps 0..n-1) -> FETCH_ADDR. HLT goes DECODE -> HALT.
- **Reset:**
  - While reset is high, control_word_o = 0, instr_done_o = 0 and halted_o = 0.
  - On the posedge where reset is sampled, state <= FETCH_ADDR, step <= 0, op_q <= NOP.
  - Reset wins in every state, including mid-EXEC and HALT.
- **Control word:** combinational (Moore) from state, step, op_q and flags. Fields not listed below are 0.
  - FETCH_ADDR: oe_pc, load_mar.
  - FETCH_INST: oe_ram, load_ir, pc_enable.
  - DECODE: op_q <= opcode_i at the end of the cycle. The control word is 0.
- **Execute steps** (operand = IR low nibble, driven with oe_ir):
  - LDA 0x1: E0 oe_ir+load_mar; E1 oe_ram+load_a.
  - ADD 0x2: E0 oe_ir+load_mar; E1 oe_ram+load_b; E2 alu_oe+alu_op=ALU_ADD+load_a+load_flags.
  - SUB 0x3: same as ADD with alu_op=ALU_SUB.
  - STA 0x4: E0 oe_ir+load_mar; E1 oe_a+load_ram.
  - LDI 0x5: E0 oe_ir+load_a.
  - JMP 0x6: E0 oe_ir+load_pc.
  - JC 0x7, JZ 0x8, JN 0x9: one step E0. The flag is sampled combinationally in E0. If the flag is 1, the step asserts oe_ir+load_pc; otherwise the control word is 0.
  - OUT 0xE: E0 oe_a+load_o.
  - NOP 0x0 and undefined opcodes: no EXEC steps; DECODE -> FETCH_ADDR.
  - HLT 0xF: DECODE -> HALT.
- **Instruction latency in cycles:**
  - NOP: 3.
  - LDI, JMP, Jcc, OUT: 4.
  - LDA, STA: 5.
  - ADD, SUB: 6.
- **Step counter:**
  - Clears to 0 on entry to EXEC and increments each EXEC cycle.
  - On the last step it returns to 0 and state goes to FETCH_ADDR.
  - It never wraps past the opcode's step count.
- **instr_done_o:** high in the last EXEC step, or in DECODE for NOP and undefined opcodes. It is never high in HALT.
- **HALT:**
  - control_word_o = 0 except the halt bit = 1; halted_o = 1.
  - Absorbing state; only reset exits it.
- **Flag timing:** flags written by ADD/SUB E2 are visible to a Jcc executing in the next instruction. They must not be sampled by Jcc in any step other than E0.

Decomposition:
- **arch_defs_pkg additions:**
  - control_word_t packed struct with fields pc_enable, load_pc, oe_pc, load_mar, oe_ram, load_ram, load_ir, oe_ir, load_a, oe_a, load_b, alu_oe, alu_op[1:0], load_flags, load_o, halt.
  - seq_state_t enum: FETCH_ADDR, FETCH_INST, DECODE, EXEC, HALT.
  - opcode_t enum with the encodings above.
  - ALU_ADD / ALU_SUB constants.
- **Sub-module microcode_rom:** purely combinational (op_q, step, flags) -> control word plus last_step. It keeps the sequencer FSM free of the opcode table.

Test Plan:
- LDA 0x1, operand 0xD -> FETCH_ADDR, FETCH_INST, DECODE, E0 (oe_ir, load_mar), E1 (oe_ram, load_a). instr_done_o high only in E1; 5 cycles total.
- ADD 0x2 -> E2 asserts alu_oe, load_a, load_flags, alu_op=ALU_ADD. Next FETCH_ADDR at cycle 7; 6 cycles total.
- JC with flag_carry_i=1 -> E0 asserts oe_ir+load_pc. With flag_carry_i=0 -> E0 control word 0. Both return to FETCH_ADDR after 4 cycles.
- HLT 0xF -> halted_o=1 and halt bit set from cycle 4. Holds for 50 cycles; no other control bit ever asserts.
- Opcodes 0xA-0xD and NOP -> DECODE goes straight to FETCH_ADDR; instr_done_o high in DECODE; 3 cycles.
- Reset pulsed during ADD E1, and during HALT -> next cycle control_word_o=0. The cycle after release is FETCH_ADDR with step_o=0 and halted_o=0.
